// File: rtl/emem_responder.sv
// -----------------------------------------------------------------------------
// emem_responder
//   External-memory-side responder for the load/store request protocol.
//   Independent load and store request channels are arbitrated onto a single
//   internal single-port word memory. Each accepted request is acknowledged
//   LATENCY cycles after acceptance with a one-cycle Ack (plus read data for
//   loads). Used as the external memory model in system simulation and as an
//   on-chip stand-in for an external RAM.
//
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous, active-high reset
//   I_Ld_Req   in   load request, held with I_Ld_Addr until O_Ld_Ack
//   I_Ld_Addr  in   load word address
//   O_Ld_Ack   out  one-cycle load acknowledge; O_Ld_Data valid this cycle
//   O_Ld_Data  out  registered load data, holds between Acks
//   I_St_Req   in   store request, held with I_St_Addr/I_St_Data until O_St_Ack
//   I_St_Addr  in   store word address
//   I_St_Data  in   store write data
//   O_St_Ack   out  one-cycle store acknowledge; write completes this cycle
//   O_Busy     out  high while an access is in progress
//   O_Err      out  sticky out-of-range access flag, cleared only by reset
// -----------------------------------------------------------------------------
module emem_responder #(
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_ADDR = 32,
    parameter int DEPTH      = 4096,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Ld_Req,
    input  logic [WIDTH_ADDR-1:0] I_Ld_Addr,
    output logic                  O_Ld_Ack,
    output logic [WIDTH_DATA-1:0] O_Ld_Data,
    input  logic                  I_St_Req,
    input  logic [WIDTH_ADDR-1:0] I_St_Addr,
    input  logic [WIDTH_DATA-1:0] I_St_Data,
    output logic                  O_St_Ack,
    output logic                  O_Busy,
    output logic                  O_Err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    // One extra bit so DEPTH is representable even when it equals 2**WIDTH_ADDR.
    localparam logic [WIDTH_ADDR:0] DEPTH_EXT = (WIDTH_ADDR + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        ST_WAIT,
        LD_ACK,
        ST_ACK
    } state_t;

    typedef enum logic {
        PRIO_LD,
        PRIO_ST
    } prio_t;

    state_t                  state_q, state_d;
    prio_t                   prio_q, prio_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [WIDTH_ADDR-1:0]   addr_q, addr_d;
    logic [WIDTH_DATA-1:0]   wdata_q, wdata_d;
    logic [WIDTH_DATA-1:0]   ld_data_q;
    logic                    err_q;
    logic                    oor_d, oor_q;
    logic                    pick_ld, pick_st;

    logic [WIDTH_DATA-1:0]   mem [DEPTH];

    // Out-of-range checks on the address being latched (d) and the held one (q).
    assign oor_d = ({1'b0, addr_d} >= DEPTH_EXT);
    assign oor_q = ({1'b0, addr_q} >= DEPTH_EXT);

    // Arbitration: a lone request wins; on a tie the priority pointer decides.
    assign pick_ld = I_Ld_Req && (!I_St_Req || prio_q == PRIO_LD);
    assign pick_st = I_St_Req && (!I_Ld_Req || prio_q == PRIO_ST);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (pick_ld) begin
                    addr_d  = I_Ld_Addr;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? LD_ACK : LD_WAIT;
                    if (I_St_Req) prio_d = PRIO_ST;
                end else if (pick_st) begin
                    addr_d  = I_St_Addr;
                    wdata_d = I_St_Data;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? ST_ACK : ST_WAIT;
                    if (I_Ld_Req) prio_d = PRIO_LD;
                end
            end
            // The counter reaching zero on this edge means the next cycle is
            // the Ack cycle, giving Ack exactly LATENCY cycles after accept.
            LD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = LD_ACK;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_ACK;
            end
            LD_ACK:  state_d = IDLE;
            ST_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            prio_q    <= PRIO_LD;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ld_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            // Read data is captured on the edge entering LD_ACK so it is
            // presented in the same cycle as O_Ld_Ack, then held.
            if (state_d == LD_ACK) begin
                ld_data_q <= oor_d ? '0 : mem[addr_d[IDX_W-1:0]];
            end
            if ((state_d == LD_ACK || state_d == ST_ACK) && oor_d) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: the memory array has no reset; its contents survive reset and a
    // reset-able RAM would not map onto memory macros.
    // Reset forces state_q to IDLE asynchronously, so a store aborted by reset
    // never reaches this write.
    always_ff @(posedge clock) begin
        if (state_q == ST_ACK && !oor_q) begin
            mem[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

    assign O_Ld_Ack  = (state_q == LD_ACK);
    assign O_St_Ack  = (state_q == ST_ACK);
    assign O_Busy    = (state_q != IDLE);
    assign O_Ld_Data = ld_data_q;
    assign O_Err     = err_q;

endmodule

// File: tb/tb_emem_responder.sv
// -----------------------------------------------------------------------------
// tb_emem_responder
//   Directed self-checking bench for emem_responder. Instance dut uses
//   LATENCY=2; instance dut1 uses LATENCY=1 for the held-request throughput
//   case. Inputs change 1 time unit after the rising edge and outputs are
//   sampled at the same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_emem_responder;

    logic        clock;
    logic        reset;

    logic        ld_req, st_req, ld_ack, st_ack, busy, err;
    logic [31:0] ld_addr, st_addr, st_data, ld_data;

    logic        ld_req1, st_req1, ld_ack1, st_ack1, busy1, err1;
    logic [31:0] ld_addr1, st_addr1, st_data1, ld_data1;

    int total = 0;
    int bad   = 0;

    emem_responder #(.WIDTH_DATA(32), .WIDTH_ADDR(32), .DEPTH(4096), .LATENCY(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .I_Ld_Req  (ld_req),
        .I_Ld_Addr (ld_addr),
        .O_Ld_Ack  (ld_ack),
        .O_Ld_Data (ld_data),
        .I_St_Req  (st_req),
        .I_St_Addr (st_addr),
        .I_St_Data (st_data),
        .O_St_Ack  (st_ack),
        .O_Busy    (busy),
        .O_Err     (err)
    );

    emem_responder #(.WIDTH_DATA(32), .WIDTH_ADDR(32), .DEPTH(4096), .LATENCY(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .I_Ld_Req  (ld_req1),
        .I_Ld_Addr (ld_addr1),
        .O_Ld_Ack  (ld_ack1),
        .O_Ld_Data (ld_data1),
        .I_St_Req  (st_req1),
        .I_St_Addr (st_addr1),
        .I_St_Data (st_data1),
        .O_St_Ack  (st_ack1),
        .O_Busy    (busy1),
        .O_Err     (err1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete access on the LATENCY=2 instance, requester dropping Req
    // right after the Ack cycle.
    task automatic access(input bit is_st, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_ld, input logic exp_err, input string tag);
        if (is_st) begin
            st_addr = addr;
            st_data = data;
            st_req  = 1'b1;
        end else begin
            ld_addr = addr;
            ld_req  = 1'b1;
        end
        tick();  // accepted on this edge; first wait cycle
        check({tag, "_wait_busy"}, busy, 1);
        check({tag, "_wait_ack"}, is_st ? st_ack : ld_ack, 0);
        tick();  // Ack cycle
        check({tag, "_ack"}, is_st ? st_ack : ld_ack, 1);
        check({tag, "_other_ack"}, is_st ? ld_ack : st_ack, 0);
        check({tag, "_err"}, err, exp_err);
        if (!is_st) check({tag, "_data"}, ld_data, exp_ld);
        ld_req = 1'b0;
        st_req = 1'b0;
        tick();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_ack"}, is_st ? st_ack : ld_ack, 0);
        if (!is_st) check({tag, "_data_hold"}, ld_data, exp_ld);
    endtask

    initial begin
        reset    = 1'b1;
        ld_req   = 1'b0; st_req  = 1'b0;
        ld_addr  = '0;   st_addr = '0;  st_data = '0;
        ld_req1  = 1'b0; st_req1 = 1'b0;
        ld_addr1 = '0;   st_addr1 = '0; st_data1 = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_busy",   busy,    0);
        check("rst_ld_ack", ld_ack,  0);
        check("rst_st_ack", st_ack,  0);
        check("rst_ldata",  ld_data, 0);
        check("rst_err",    err,     0);
        reset = 1'b0;
        tick();

        // Store then load back.
        access(1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, "st_10");
        access(1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "ld_10");
        access(1'b1, 32'h20, 32'h7,        32'h0,        1'b0, "st_20_init");

        // First simultaneous pair: pointer at LOAD, so load wins with old data.
        ld_addr = 32'h20; st_addr = 32'h20; st_data = 32'h5;
        ld_req  = 1'b1;   st_req  = 1'b1;
        tick();
        check("p1_wait_busy", busy, 1);
        check("p1_wait_acks", {ld_ack, st_ack}, 0);
        tick();
        check("p1_ld_ack",  ld_ack,  1);
        check("p1_st_ack0", st_ack,  0);
        check("p1_ld_data", ld_data, 32'h7);
        ld_req = 1'b0;
        tick();
        check("p1_gap_busy", busy, 0);
        check("p1_gap_acks", {ld_ack, st_ack}, 0);
        tick();
        check("p1_st_wait", st_ack, 0);
        tick();
        check("p1_st_ack",  st_ack, 1);
        check("p1_ld_ack0", ld_ack, 0);
        st_req = 1'b0;
        tick();

        // Second pair: pointer flipped to STORE, so the load sees the new data.
        st_data = 32'h9;
        ld_req  = 1'b1; st_req = 1'b1;
        tick();
        tick();
        check("p2_st_ack",  st_ack, 1);
        check("p2_ld_ack0", ld_ack, 0);
        st_req = 1'b0;
        tick();
        tick();
        tick();
        check("p2_ld_ack",  ld_ack,  1);
        check("p2_st_ack0", st_ack,  0);
        check("p2_ld_data", ld_data, 32'h9);
        ld_req = 1'b0;
        tick();

        // Out-of-range accesses.
        access(1'b1, 32'h0,    32'h12345678, 32'h0,        1'b0, "st_0");
        access(1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, "ld_oor");
        access(1'b1, 32'h1000, 32'h00000BAD, 32'h0,        1'b1, "st_oor");
        access(1'b0, 32'h0,    32'h0,        32'h12345678, 1'b1, "ld_0_after_oor");
        check("err_sticky", err, 1);

        // Reset in the middle of a store aborts it without writing.
        access(1'b1, 32'h30, 32'hAAAA, 32'h0, 1'b1, "st_30");
        access(1'b0, 32'h30, 32'h0, 32'hAAAA, 1'b1, "ld_30");
        st_addr = 32'h30; st_data = 32'h1; st_req = 1'b1;
        tick();
        check("abort_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy",   busy,    0);
        check("abort_st_ack", st_ack,  0);
        check("abort_ld_ack", ld_ack,  0);
        check("abort_ldata",  ld_data, 0);
        check("abort_err",    err,     0);
        st_req = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        check("abort_no_ack", st_ack, 0);
        tick();
        check("abort_no_ack2", st_ack, 0);
        access(1'b0, 32'h30, 32'h0, 32'hAAAA, 1'b0, "ld_30_after_abort");

        // LATENCY=1: requests held continuously, Acks every second cycle.
        st_addr1 = 32'h3; st_data1 = 32'h33; st_req1 = 1'b1;
        tick();
        check("l1_st3_ack",  st_ack1, 1);
        check("l1_st3_busy", busy1,   1);
        st_addr1 = 32'h4; st_data1 = 32'h44;
        tick();
        check("l1_st_gap_ack",  st_ack1, 0);
        check("l1_st_gap_busy", busy1,   0);
        tick();
        check("l1_st4_ack", st_ack1, 1);
        st_req1 = 1'b0;
        tick();
        check("l1_st_idle", busy1, 0);

        ld_addr1 = 32'h3; ld_req1 = 1'b1;
        tick();
        check("l1_ld3_ack",  ld_ack1,  1);
        check("l1_ld3_busy", busy1,    1);
        check("l1_ld3_data", ld_data1, 32'h33);
        ld_addr1 = 32'h4;
        tick();
        check("l1_gap1_ack",  ld_ack1, 0);
        check("l1_gap1_busy", busy1,   0);
        tick();
        check("l1_ld4_ack",  ld_ack1,  1);
        check("l1_ld4_busy", busy1,    1);
        check("l1_ld4_data", ld_data1, 32'h44);
        ld_addr1 = 32'h3;
        tick();
        check("l1_gap2_ack",  ld_ack1,  0);
        check("l1_gap2_hold", ld_data1, 32'h44);
        tick();
        check("l1_ld3b_ack",  ld_ack1,  1);
        check("l1_ld3b_data", ld_data1, 32'h33);
        ld_req1 = 1'b0;
        tick();
        check("l1_end_busy", busy1,   0);
        check("l1_end_ack",  ld_ack1, 0);
        check("l1_err",      err1,    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/emem_responder.md
Name: emem_responder

Overview:
External-memory-side responder for the load/store request protocol driven by the external memory load/store interface. It accepts independent load and store request channels and arbitrates them onto one internal single-port word memory. It returns a one-cycle acknowledge, plus read data for loads, after a fixed access latency. It is used as the external memory model in system simulation and as the on-chip stand-in for an external RAM.

Parameters:
WIDTH_DATA, 32, data word width in bits
WIDTH_ADDR, 32, word address width (matches external address width)
DEPTH, 4096, number of words in the internal memory (power of two)
LATENCY, 2, cycles from request acceptance to acknowledge (1..15)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
I_Ld_Req  in  1  load request; held high with I_Ld_Addr stable until O_Ld_Ack
I_Ld_Addr  in  WIDTH_ADDR  load word address
O_Ld_Ack  out  1  one-cycle load acknowledge; O_Ld_Data is valid in this cycle
O_Ld_Data  out  WIDTH_DATA  load read data (registered)
I_St_Req  in  1  store request; held high with I_St_Addr and I_St_Data stable until O_St_Ack
I_St_Addr  in  WIDTH_ADDR  store word address
I_St_Data  in  WIDTH_DATA  store write data
O_St_Ack  out  1  one-cycle store acknowledge; the write has completed in this cycle
O_Busy  out  1  high while an access is in progress (state is not IDLE)
O_Err  out  1  sticky flag: an out-of-range address was accessed; cleared only by reset

Behaviour:
- Reset (asynchronous): all outputs 0, FSM goes to IDLE, latency counter 0, priority pointer set to LOAD. Memory contents are not cleared.
- A reset asserted mid-access aborts the access. No Ack is issued. A store aborted before its Ack cycle does not write.
- FSM states:
  - IDLE: samples I_Ld_Req and I_St_Req.
    - Only one request high: accept it.
    - Both high: accept the channel named by the priority pointer, then flip the pointer to the other channel.
    - Single-channel acceptance leaves the pointer unchanged.
    - On accept, latch the address (and write data for stores), load the counter with LATENCY-1, and go to LD_WAIT or ST_WAIT. If LATENCY=1, go directly to the Ack cycle.
  - LD_WAIT / ST_WAIT: decrement the counter each cycle. When the counter is 0, go to LD_ACK / ST_ACK.
  - LD_ACK:
    - Performs the read; O_Ld_Data is registered so that it is valid in the same cycle O_Ld_Ack=1.
    - Returns to IDLE.
    - O_Ld_Data holds its last value outside Ack cycles.
  - ST_ACK: performs the write on the clock edge ending this cycle, asserts O_St_Ack=1, and returns to IDLE.
- Latency: a request accepted in cycle c is acknowledged in cycle c+LATENCY.
- Request/Ack protocol:
  - The requester drops Req the cycle after Ack.
  - The responder samples Req only in IDLE, i.e. from cycle Ack+1 onward. A Req still high at Ack+1 is treated as a new request.
  - Throughput per channel is therefore one word per LATENCY+1 cycles.
- Memory index is I_*_Addr[log2(DEPTH)-1:0]. An address >= DEPTH is out of range:
  - Load returns all-zero data.
  - Store is discarded.
  - Ack is still given and O_Err is set to 1 in the Ack cycle.
- Ordering: a load and a store to the same address requested in the same cycle execute in arbitration order. A load accepted after a store's Ack returns the new data.
- O_Ld_Ack and O_St_Ack are never high in the same cycle.
- A request deasserted before its Ack is a protocol violation. The access still completes from the latched values.

Test Plan:
- Reset then store: I_St_Req with addr 0x10, data 0xDEADBEEF, LATENCY=2, accepted at cycle 1 -> O_St_Ack=1 at cycle 3 only; O_Busy=1 in cycles 2-3.
- Load after store: I_Ld_Req addr 0x10 -> O_Ld_Ack=1 exactly 2 cycles after acceptance with O_Ld_Data=0xDEADBEEF; O_Ld_Data holds afterwards.
- Simultaneous requests, issued twice back-to-back: store addr 0x20 data 0x5 and load addr 0x20 (memory initially 0x7) -> first pair: load acked first with 0x7, then store acked. Second pair: store acked first, then load returns 0x5.
- Out of range: load addr DEPTH (0x1000) -> Ack with data 0, O_Err=1 and stays 1. Store to 0x1000 -> Ack given, and a load from addr 0 is unchanged.
- Reset mid-access: store addr 0x30 data 0x1 accepted, reset pulsed before Ack -> no O_St_Ack, outputs 0. A following load of 0x30 returns the prior contents.
- LATENCY=1 build: back-to-back loads with Req held continuously -> Acks every 2 cycles, each with correct data; O_Busy high in Ack cycles only.
